// File: rtl/switch_conditioner_pkg.sv
// Shared switch-bus definitions for the conditioner and the go/nogo counter.
// Field offsets assume the default NBITS layout of the raw switch bus.
package switch_conditioner_pkg;

  localparam int NBITS       = 12;
  localparam int SW_GO_LSB   = 0;
  localparam int SW_NOGO_LSB = NBITS;
  localparam int SW_SEL_GO   = 2 * NBITS;
  localparam int SW_SEL_NOGO = 2 * NBITS + 1;
  localparam int SW_LED_EN   = 2 * NBITS + 2;
  localparam int SW_WIDTH    = 2 * NBITS + 3;

  typedef struct packed {
    logic             led_enable;
    logic             sel_nogo;
    logic             sel_go;
    logic [NBITS-1:0] nogo;
    logic [NBITS-1:0] go;
  } sw_fields_t;

  function automatic int CYCLES_PER_MS(input int clock_mhz);
    return clock_mhz * 1000;
  endfunction

endpackage

// File: rtl/switch_conditioner_if.sv
// Raw switch levels in, debounced vector with change strobe and valid flag out.
// master is the conditioner side; slave is the switch source / consumer side.
interface switch_conditioner_if
  import switch_conditioner_pkg::*;
#(
  parameter int W = SW_WIDTH
);
  logic [W-1:0] sw_raw;
  logic [W-1:0] sw_clean;
  logic         sw_changed;
  logic         sw_valid;

  modport master (input sw_raw, output sw_clean, output sw_changed, output sw_valid);
  modport slave  (output sw_raw, input sw_clean, input sw_changed, input sw_valid);
endinterface

// File: rtl/switch_conditioner_ms_tick_gen.sv
// Free-running millisecond time base: one-cycle pulse each time the counter
// wraps to zero; never disturbed by anything but reset.
module ms_tick_gen
  import switch_conditioner_pkg::*;
#(
  parameter int CLOCK_MHZ = 12
) (
  input  logic clk,
  input  logic rst,
  output logic ms_tick
);
  localparam int CYCLES = CYCLES_PER_MS(CLOCK_MHZ);
  localparam int CW     = $clog2(CYCLES);

  logic [CW-1:0] count_reg;
  logic          ms_tick_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      count_reg   <= '0;
      ms_tick_reg <= 1'b0;
    end else if (count_reg == CW'(CYCLES - 1)) begin
      count_reg   <= '0;
      ms_tick_reg <= 1'b1;
    end else begin
      count_reg   <= count_reg + 1'b1;
      ms_tick_reg <= 1'b0;
    end
  end

  assign ms_tick = ms_tick_reg;
endmodule

// File: rtl/switch_conditioner.sv
// Synchronise, debounce (whole vector on a 1 ms base) and register the
// configuration switch bus, with a one-cycle strobe on every committed update.
module switch_conditioner #(
  parameter int NBITS       = switch_conditioner_pkg::NBITS,
  parameter int W           = 2 * NBITS + 3,
  parameter int CLOCK_MHZ   = 12,
  parameter int DEBOUNCE_MS = 20,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  switch_conditioner_if.master sw
);
  localparam int             SCW        = $clog2(DEBOUNCE_MS + 1);
  localparam logic [SCW-1:0] STABLE_MAX = SCW'(DEBOUNCE_MS);

  logic                            ms_tick;
  logic [SYNC_STAGES-1:0][W-1:0]   sync_reg;
  logic [W-1:0]                    sync;
  logic [W-1:0]                    cand_reg;
  logic [W-1:0]                    clean_reg;
  logic [SCW-1:0]                  stable_cnt_reg;
  logic                            changed_reg;
  logic                            valid_reg;
  logic                            commit;

  ms_tick_gen #(.CLOCK_MHZ(CLOCK_MHZ)) u_tick (
    .clk     (clk),
    .rst     (rst),
    .ms_tick (ms_tick)
  );

  always_ff @(posedge clk) begin
    if (rst) sync_reg <= '0;
    else     sync_reg <= {sync_reg[SYNC_STAGES-2:0], sw.sw_raw};
  end

  assign sync = sync_reg[SYNC_STAGES-1];

  // The first commit after reset must fire even if the vector equals the reset value.
  assign commit = (stable_cnt_reg == STABLE_MAX) && (!valid_reg || (cand_reg != clean_reg));

  always_ff @(posedge clk) begin
    if (rst) begin
      cand_reg       <= '0;
      stable_cnt_reg <= '0;
      clean_reg      <= '0;
      changed_reg    <= 1'b0;
      valid_reg      <= 1'b0;
    end else begin
      // A mismatch restarts the window even if a tick lands in the same cycle.
      if (sync != cand_reg) begin
        cand_reg       <= sync;
        stable_cnt_reg <= '0;
      end else if (ms_tick && (stable_cnt_reg < STABLE_MAX)) begin
        stable_cnt_reg <= stable_cnt_reg + SCW'(1);
      end

      if (commit) begin
        clean_reg   <= cand_reg;
        changed_reg <= 1'b1;
        valid_reg   <= 1'b1;
      end else begin
        changed_reg <= 1'b0;
      end
    end
  end

  assign sw.sw_clean   = clean_reg;
  assign sw.sw_changed = changed_reg;
  assign sw.sw_valid   = valid_reg;
endmodule
